// File: rtl/zl_fifo_pkg.sv
// Shared definitions for the zl_fifo family: depth macro, occupancy width helper and
// status bit positions used when packing overflow/underflow into CSRs.
`ifndef ZL_FIFO_DEPTH
`define ZL_FIFO_DEPTH(aw) (1 << (aw))
`endif

package zl_fifo_pkg;

    localparam int ZL_STAT_OVF = 0;
    localparam int ZL_STAT_UNF = 1;
    localparam int ZL_STAT_W   = 2;

    // Occupancy must represent 0..Depth inclusive, hence one bit more than the address.
    function automatic int zl_used_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/zl_ram_sdp.sv
// Simple dual-port RAM, one write port and one registered read port. The read register
// only updates on rd_en, so it doubles as the first prefetch stage of the FIFO.
module zl_ram_sdp #(
    parameter int Data_width = 8,
    parameter int Addr_width = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [Addr_width-1:0] wr_addr,
    input  logic [Data_width-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [Addr_width-1:0] rd_addr,
    output logic [Data_width-1:0] rd_data
);

    logic [Data_width-1:0] mem_r [0:(2**Addr_width)-1];
    logic [Data_width-1:0] rd_data_r;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port, holds its value when not enabled
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/zl_fifo_sc_gen.sv
// Single-clock show-ahead FIFO: inferred RAM plus prefetch pipeline, exact occupancy,
// almost flags, flush and sticky errors. Optional ZL_FIFO_SC_GEN_OUT_REG_EN adds an output register.
module zl_fifo_sc_gen
    import zl_fifo_pkg::*;
#(
    parameter int Data_width   = 8,
    parameter int Addr_width   = 4,
    parameter int Afull_level  = 12,
    parameter int Aempty_level = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_req,
    output logic                  in_ack,
    input  logic [Data_width-1:0] in_data,
    output logic                  out_req,
    input  logic                  out_ack,
    output logic [Data_width-1:0] out_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [Addr_width:0]   used,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = `ZL_FIFO_DEPTH(Addr_width);
    localparam int UW    = zl_used_width(Addr_width);

    logic [Addr_width-1:0] wr_ptr_r;
    logic [Addr_width-1:0] rd_ptr_r;
    logic [UW-1:0]         used_r;
    logic [UW-1:0]         used_nxt_s;
    logic [UW-1:0]         stage_cnt_s;
    logic [UW-1:0]         ram_cnt_s;
    logic                  full_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;
    logic [ZL_STAT_W-1:0]  status_r;

    logic                  clr_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic                  a_free_s;
    logic                  b_load_s;
    logic                  b_take_s;
    logic                  out_valid_s;
    logic [Data_width-1:0] out_data_s;
    logic [Data_width-1:0] ram_rd_data_s;

    // Stage A is the RAM read register, stage B the prefetch register.
    logic                  a_valid_r;
    logic                  b_valid_r;
    logic [Data_width-1:0] b_data_r;
`ifdef ZL_FIFO_SC_GEN_OUT_REG_EN
    logic                  c_valid_r;
    logic [Data_width-1:0] c_data_r;
    logic                  c_load_s;
`endif

    zl_ram_sdp #(
        .Data_width (Data_width),
        .Addr_width (Addr_width)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (in_data),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r),
        .rd_data (ram_rd_data_s)
    );

    // Handshake, pipeline advance and occupancy next-state
    always_comb begin
        clr_s  = rst || flush;
        push_s = in_req && !full_r;
        pop_s  = out_ack && out_valid_s;
`ifdef ZL_FIFO_SC_GEN_OUT_REG_EN
        c_load_s    = b_valid_r && (!c_valid_r || pop_s);
        b_take_s    = c_load_s;
        stage_cnt_s = UW'(a_valid_r) + UW'(b_valid_r) + UW'(c_valid_r);
`else
        b_take_s    = pop_s;
        stage_cnt_s = UW'(a_valid_r) + UW'(b_valid_r);
`endif
        b_load_s  = a_valid_r && (!b_valid_r || b_take_s);
        a_free_s  = !a_valid_r || b_load_s;
        // Words still sitting in RAM; reads never target the write address because
        // a read needs ram_cnt_s > 0 and the pipeline drains RAM before it can fill.
        ram_cnt_s = used_r - stage_cnt_s;
        rd_en_s   = !clr_s && a_free_s && (ram_cnt_s != {UW{1'b0}});
        wr_en_s   = !clr_s && push_s;
        case ({push_s, pop_s})
            2'b10:   used_nxt_s = used_r + UW'(1);
            2'b01:   used_nxt_s = used_r - UW'(1);
            default: used_nxt_s = used_r;
        endcase
    end

    // Pointers, occupancy, level flags and sticky errors
    always_ff @(posedge clk) begin
        if (clr_s) begin
            wr_ptr_r       <= {Addr_width{1'b0}};
            rd_ptr_r       <= {Addr_width{1'b0}};
            used_r         <= {UW{1'b0}};
            full_r         <= 1'b0;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            status_r       <= {ZL_STAT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + Addr_width'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + Addr_width'(1);
            end
            used_r         <= used_nxt_s;
            full_r         <= (used_nxt_s == UW'(DEPTH));
            almost_full_r  <= (used_nxt_s >= UW'(Afull_level));
            almost_empty_r <= (used_nxt_s <= UW'(Aempty_level));
            if (in_req && full_r) begin
                status_r[ZL_STAT_OVF] <= 1'b1;
            end
            if (out_ack && !out_valid_s) begin
                status_r[ZL_STAT_UNF] <= 1'b1;
            end
        end
    end

    // Prefetch pipeline; clearing the valids discards any in-flight RAM read
    always_ff @(posedge clk) begin
        if (clr_s) begin
            a_valid_r <= 1'b0;
            b_valid_r <= 1'b0;
            b_data_r  <= {Data_width{1'b0}};
`ifdef ZL_FIFO_SC_GEN_OUT_REG_EN
            c_valid_r <= 1'b0;
            c_data_r  <= {Data_width{1'b0}};
`endif
        end else begin
            a_valid_r <= rd_en_s || (a_valid_r && !b_load_s);
            b_valid_r <= b_load_s || (b_valid_r && !b_take_s);
            if (b_load_s) begin
                b_data_r <= ram_rd_data_s;
            end
`ifdef ZL_FIFO_SC_GEN_OUT_REG_EN
            c_valid_r <= c_load_s || (c_valid_r && !pop_s);
            if (c_load_s) begin
                c_data_r <= b_data_r;
            end
`endif
        end
    end

`ifdef ZL_FIFO_SC_GEN_OUT_REG_EN
    assign out_valid_s = c_valid_r;
    assign out_data_s  = c_data_r;
`else
    assign out_valid_s = b_valid_r;
    assign out_data_s  = b_data_r;
`endif

    assign in_ack       = push_s;
    assign out_req      = out_valid_s;
    assign out_data     = out_data_s;
    assign empty        = !out_valid_s;
    assign full         = full_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
    assign used         = used_r;
    assign overflow     = status_r[ZL_STAT_OVF];
    assign underflow    = status_r[ZL_STAT_UNF];

endmodule

// File: tb/tb_zl_fifo_sc_gen.sv
// Scoreboard bench for zl_fifo_sc_gen: stimulus pushes expected words into a queue,
// a negedge monitor checks occupancy, flags and popped data against a reference model.
module tb_zl_fifo_sc_gen;

    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 12;
    localparam int AEMPTY = 2;
`ifdef ZL_FIFO_SC_GEN_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_req = 1'b0;
    logic          out_ack = 1'b0;
    logic [DW-1:0] in_data = 8'h00;
    logic          in_ack, out_req, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [DW-1:0] out_data;
    logic [AW:0]   used;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q[$];
    int m_used = 0;
    bit m_ovf  = 1'b0;
    bit m_unf  = 1'b0;
    bit chk_en = 1'b0;

    zl_fifo_sc_gen #(
        .Data_width   (DW),
        .Addr_width   (AW),
        .Afull_level  (AFULL),
        .Aempty_level (AEMPTY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_req       (in_req),
        .in_ack       (in_ack),
        .in_data      (in_data),
        .out_req      (out_req),
        .out_ack      (out_ack),
        .out_data     (out_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .used         (used),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against model state, then advance model to the next edge
    always @(negedge clk) begin
        logic          m_full;
        logic [DW-1:0] e;
        if (chk_en) begin
            chk("used", used, m_used);
            chk("full", full, m_used == DEPTH);
            chk("almost_full", almost_full, m_used >= AFULL);
            chk("almost_empty", almost_empty, m_used <= AEMPTY);
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_unf);
            chk("empty", empty, !out_req);
            chk("in_ack", in_ack, in_req && (m_used != DEPTH));
            if (m_used == 0) chk("idle_out_req", out_req, 0);
            if (out_req && out_ack) begin
                chk("pop_has_data", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                end
            end
        end
        if (rst || flush) begin
            exp_q.delete();
            m_used = 0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            m_full = (m_used == DEPTH);
            if (in_req && m_full) m_ovf = 1'b1;
            if (out_ack && !out_req) m_unf = 1'b1;
            if (out_req && out_ack) m_used--;
            if (in_req && !m_full) begin
                exp_q.push_back(in_data);
                m_used++;
            end
        end
        if (rst) chk_en = 1'b1;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int sent;
        int cyc;
        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_req", out_req, 0);
        repeat (3) @(posedge clk);

        // Latency from a single write into an empty FIFO
        #1 in_req = 1'b1; in_data = 8'hA5;
        @(posedge clk);
        #1 in_req = 1'b0;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            chk("latency_out_req", out_req, k == LAT);
        end
        chk("latency_out_data", out_data, 8'hA5);
        @(posedge clk); #1 out_ack = 1'b1;
        @(posedge clk); #1 out_ack = 1'b0;

        // Fill to full, then keep requesting to trip overflow
        in_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = 8'(i);
            @(posedge clk); #1;
        end
        in_data = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("fill_full", full, 1);
        chk("fill_overflow", overflow, 1);
        chk("fill_in_ack", in_ack, 0);

        // Full with simultaneous push and pop: only the pop happens
        @(posedge clk); #1 out_ack = 1'b1;
        @(posedge clk); #1 out_ack = 1'b0; in_req = 1'b0;
        @(negedge clk);
        chk("full_pushpop_used", used, 15);

        // Drain past empty to set underflow
        @(posedge clk); #1 out_ack = 1'b1;
        repeat (24) @(posedge clk);
        #1 out_ack = 1'b0;
        @(negedge clk);
        chk("drain_used", used, 0);
        chk("drain_underflow", underflow, 1);

        // Flush with seven words held and push/pop active
        @(posedge clk); #1 in_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = 8'h30 + 8'(i);
            @(posedge clk); #1;
        end
        in_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 flush = 1'b1; in_req = 1'b1; out_ack = 1'b1; in_data = 8'h77;
        @(posedge clk);
        #1 flush = 1'b0; in_req = 1'b0; out_ack = 1'b0;
        @(negedge clk);
        chk("flush_used", used, 0);
        chk("flush_empty", empty, 1);
        chk("flush_overflow", overflow, 0);
        chk("flush_underflow", underflow, 0);
        repeat (4) @(posedge clk);

        // Reset while reads are in flight
        #1 in_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h50 + 8'(i);
            @(posedge clk); #1;
        end
        out_ack = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1; in_data = 8'h99;
        @(posedge clk);
        #1 rst = 1'b0; in_req = 1'b0; out_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_out_req", out_req, 0);
        end

        // Streaming with random handshakes and incrementing data
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 6000) begin
            @(posedge clk); #1;
            in_req  = ($urandom_range(0, 3) != 0) && !full;
            in_data = 8'(sent);
            out_ack = out_req && ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_ack) sent++;
            cyc++;
        end
        chk("stream_sent", sent >= 1000, 1);
        @(posedge clk); #1 in_req = 1'b0;
        cyc = 0;
        while (used != 0 && cyc < 64) begin
            out_ack = out_req;
            @(posedge clk); #1;
            cyc++;
        end
        out_ack = 1'b0;
        @(negedge clk);
        chk("stream_drained", used, 0);
        chk("stream_overflow", overflow, 0);
        chk("stream_underflow", underflow, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
